sha256_nonce_sequencer: RTL

- Mining front-end that sits directly upstream and downstream of two chained SHA-256 transform instances (first hash, second hash).
- Loads a work unit (midstate + 96-bit header tail) and issues one nonce every LOOP cycles.
- Drives the shared cnt/feedback sequencing and builds both transform input blocks.
- Checks second-hash results and reports golden nonces through a valid/ready result port.

---
 rtl/sha256_nonce_sequencer_pkg.sv | 20 ++
 rtl/sha256_result_slot.sv | 55 +++++
 rtl/sha256_nonce_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sha256_nonce_sequencer_pkg.sv
// Shared constants, state encoding and golden-hash test for the nonce sequencer.
package sha256_nonce_sequencer_pkg;

    localparam logic [31:0] PAD0_HI = 32'h00000280;
    localparam logic [31:0] PAD_END = 32'h80000000;
    localparam logic [31:0] PAD1_HI = 32'h00000100;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } seq_state_e;

    // A second-hash result is golden when its top 32-bit word is all zero.
    function automatic logic is_golden(input logic [255:0] hash);
        return hash[255:224] == 32'h0;
    endfunction

endpackage

// File: rtl/sha256_result_slot.sv
// Single-entry valid/ready result holding register with a sticky overflow flag.
module sha256_result_slot (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic [31:0] push_nonce_i,
    input  logic        clr_ovf_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] nonce_o,
    output logic        overflow_o
);

    logic        valid_q, valid_d;
    logic [31:0] nonce_q, nonce_d;
    logic        ovf_q, ovf_d;

    always_comb begin
        valid_d = valid_q;
        nonce_d = nonce_q;
        ovf_d   = ovf_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        // A push landing on the handshake cycle refills the slot without loss.
        if (push_i) begin
            if (!valid_q || ready_i) begin
                valid_d = 1'b1;
                nonce_d = push_nonce_i;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            nonce_q <= 32'h0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            nonce_q <= nonce_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o    = valid_q;
    assign nonce_o    = nonce_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/sha256_nonce_sequencer.sv
// Nonce issue / golden-check front-end for two chained SHA-256 transforms.
// Optional per-work nonce stride enabled by defining SHA256_NONCE_STRIDE_EN.
module sha256_nonce_sequencer
    import sha256_nonce_sequencer_pkg::*;
#(
    parameter int unsigned LOOP      = 4,
    parameter int unsigned NONCE_LAG = 34
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] work_midstate,
    input  logic [95:0]  work_data,
    input  logic [31:0]  nonce_start,
`ifdef SHA256_NONCE_STRIDE_EN
    input  logic [31:0]  nonce_stride,
`endif
    output logic [5:0]   tf_cnt,
    output logic         tf_feedback,
    output logic [255:0] tf0_state,
    output logic [511:0] tf0_input,
    input  logic [255:0] hash0,
    output logic [511:0] tf1_input,
    input  logic [255:0] hash1,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [31:0]  result_nonce,
    output logic         result_overflow,
    output logic         busy
);

    localparam logic [5:0]  CntLast = 6'(LOOP - 1);
    localparam logic [31:0] Lag     = 32'(NONCE_LAG);

    seq_state_e   state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [255:0] midstate_q, midstate_d;
    logic [95:0]  data_q, data_d;
    logic [31:0]  nonce_q, nonce_d;
    logic [31:0]  issued_q, issued_d;
    logic [31:0]  drain_q, drain_d;
    logic [31:0]  stride;

`ifdef SHA256_NONCE_STRIDE_EN
    logic [31:0] stride_q, stride_d;
    assign stride = stride_q;
`else
    assign stride = 32'd1;
`endif

    logic        accept;
    logic [32:0] nonce_nxt;
    logic [5:0]  cnt_wrap;
    logic        check_slot;
    logic        golden;
    logic [31:0] golden_nonce;

    assign accept       = work_valid;
    assign nonce_nxt    = {1'b0, nonce_q} + {1'b0, stride};
    assign cnt_wrap     = (cnt_q == CntLast) ? 6'd0 : cnt_q + 6'd1;
    // Accept cycle checks are dropped: they would belong to the aborted work.
    assign check_slot   = (state_q == StRun || state_q == StDrain) && (cnt_q == 6'd0) &&
                          (issued_q >= Lag) && !accept;
    assign golden       = check_slot && is_golden(hash1);
    assign golden_nonce = nonce_q - Lag * stride;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        midstate_d = midstate_q;
        data_d     = data_q;
        nonce_d    = nonce_q;
        issued_d   = issued_q;
        drain_d    = drain_q;
`ifdef SHA256_NONCE_STRIDE_EN
        stride_d   = stride_q;
`endif
        unique case (state_q)
            StRun: begin
                cnt_d = cnt_wrap;
                if (cnt_q == CntLast) begin
                    nonce_d  = nonce_nxt[31:0];
                    issued_d = (issued_q < Lag) ? issued_q + 32'd1 : issued_q;
                    if (nonce_nxt[32]) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                cnt_d = cnt_wrap;
                if (cnt_q == 6'd0) begin
                    drain_d = drain_q + 32'd1;
                    if (drain_q + 32'd1 == Lag) begin
                        state_d = StDone;
                        cnt_d   = 6'd0;
                    end
                end
            end
            StIdle, StDone: begin
                cnt_d = 6'd0;
            end
        endcase
        if (accept) begin
            state_d    = StRun;
            cnt_d      = 6'd0;
            midstate_d = work_midstate;
            data_d     = work_data;
            nonce_d    = nonce_start;
            issued_d   = 32'd0;
            drain_d    = 32'd0;
`ifdef SHA256_NONCE_STRIDE_EN
            stride_d   = nonce_stride;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 6'd0;
            midstate_q <= 256'h0;
            data_q     <= 96'h0;
            nonce_q    <= 32'h0;
            issued_q   <= 32'h0;
            drain_q    <= 32'h0;
`ifdef SHA256_NONCE_STRIDE_EN
            stride_q   <= 32'h0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            midstate_q <= midstate_d;
            data_q     <= data_d;
            nonce_q    <= nonce_d;
            issued_q   <= issued_d;
            drain_q    <= drain_d;
`ifdef SHA256_NONCE_STRIDE_EN
            stride_q   <= stride_d;
`endif
        end
    end

    sha256_result_slot u_result_slot (
        .clk          (clk),
        .reset        (reset),
        .push_i       (golden),
        .push_nonce_i (golden_nonce),
        .clr_ovf_i    (accept),
        .ready_i      (result_ready),
        .valid_o      (result_valid),
        .nonce_o      (result_nonce),
        .overflow_o   (result_overflow)
    );

    assign work_ready  = 1'b1;
    assign busy        = (state_q != StIdle) && (state_q != StDone);
    assign tf_cnt      = cnt_q;
    assign tf_feedback = (cnt_q != 6'd0);
    assign tf0_state   = midstate_q;
    assign tf0_input   = {PAD0_HI, 320'h0, PAD_END, nonce_q, data_q};
    assign tf1_input   = {PAD1_HI, 192'h0, PAD_END, hash0};

endmodule
